// File: rtl/mcu_spi_pkg.sv
// mcu_spi_pkg: shared state type and sizing constants for the MCU SPI slave.
package mcu_spi_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;
  localparam int SPI_BYTE_BITS      = 8;
  localparam int TIMEOUT_CYCLES_DEF = 50000;
endpackage

// File: rtl/spi_sync.sv
// spi_sync: multi-flop synchronizer with one extra stage for rise/fall detection.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end
  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;
endmodule

// File: rtl/mcu_spi.sv
// mcu_spi: mode-0 SPI slave moving bytes between an MCU and the clk domain.
// Define MCU_SPI_TIMEOUT_EN to abort frames whose SCK stalls for TIMEOUT_CYCLES.
module mcu_spi
  import mcu_spi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_io_ss,
  input  logic       spi_io_clk,
  input  logic       spi_io_din,
  output logic       spi_io_dout,
  output logic       data_in_strobe,
  output logic       data_in_start,
  output logic [7:0] data_in,
  input  logic [7:0] data_out,
  output logic       timeout
);
  localparam int BW = SPI_BYTE_BITS;
  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [BW-1:0]        rx_q, rx_d, tx_q, tx_d, din_q, din_d;
  logic                 strobe_q, start_q, start_d, first_q, first_d, load_q, armed_q;
  logic [SYNC_STAGES:0] settle_q;
  logic                 ss_lvl, ss_rise, ss_fall, sck_rise, sck_fall, mosi, unused_sck_lvl;
  logic [1:0]           unused_mosi_edges;
  logic                 go, shifting, wrap, abort;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk(clk), .reset_n(reset_n), .d(spi_io_ss),
    .level(ss_lvl), .rise(ss_rise), .fall(ss_fall)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .reset_n(reset_n), .d(spi_io_clk),
    .level(unused_sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .reset_n(reset_n), .d(spi_io_din),
    .level(mosi), .rise(unused_mosi_edges[0]), .fall(unused_mosi_edges[1])
  );

  // An SS fall is only a frame start once SS has been seen high since reset.
  assign go       = ss_fall && armed_q && state_q == IDLE;
  assign shifting = state_q == SHIFT && !ss_rise;
  assign wrap     = shifting && sck_rise && cnt_q == 3'd7;

  always_comb begin
    state_d = ss_rise ? IDLE : go ? SHIFT : state_q;
    cnt_d   = (ss_rise || abort) ? '0 : (shifting && sck_rise) ? cnt_q + 3'd1 : cnt_q;
    rx_d    = (ss_rise || abort) ? '0 : (shifting && sck_rise) ? {rx_q[BW-2:0], mosi} : rx_q;
    tx_d    = (go || load_q) ? data_out
            : (shifting && sck_fall && cnt_q != 3'd0) ? {tx_q[BW-2:0], 1'b0} : tx_q;
    first_d = (go || abort) ? 1'b1 : wrap ? 1'b0 : first_q;
    din_d   = wrap ? {rx_q[BW-2:0], mosi} : din_q;
    start_d = wrap ? first_q : start_q;
  end

  // The fall following a byte's last rise is covered by the reload, not a shift.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rx_q     <= '0;
      tx_q     <= '0;
      din_q    <= '0;
      strobe_q <= 1'b0;
      start_q  <= 1'b0;
      first_q  <= 1'b1;
      load_q   <= 1'b0;
      armed_q  <= 1'b0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      din_q    <= din_d;
      strobe_q <= wrap;
      start_q  <= start_d;
      first_q  <= first_d;
      load_q   <= strobe_q;
      settle_q <= {settle_q[SYNC_STAGES-1:0], 1'b1};
      armed_q  <= armed_q | (&settle_q & ss_lvl);
    end
  end

`ifdef MCU_SPI_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);
  logic [TW-1:0] to_cnt_q, to_inc;
  logic          timeout_q;
  assign to_inc = (state_q == SHIFT && !ss_rise && !sck_rise && !sck_fall) ? to_cnt_q + TW'(1) : '0;
  assign abort  = to_inc == TO_MAX;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= abort ? '0 : to_inc;
      timeout_q <= abort;
    end
  end
  assign timeout = timeout_q;
`else
  assign abort   = 1'b0;
  assign timeout = 1'b0;
`endif

  assign spi_io_dout    = ~ss_lvl & tx_q[BW-1];
  assign data_in        = din_q;
  assign data_in_strobe = strobe_q;
  assign data_in_start  = start_q;
endmodule
